bpu_seq: RTL and testbench

Instruction sequencer and result collector for one BPU. It accepts a job command (optional 7x7 kernel, height, right shift, window count) and drives the BPU's serial weight load and 5-bit instruction stream. For each window it captures the signed popcount accumulation and returns it over a valid/ready result port. It sits between the layer controller and the BPU, while the image feeder steps windows on `win_next`.

---
 rtl/bpu_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_bpu_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_seq.sv
// bpu_seq: instruction sequencer and result collector for one BPU.
//
// Takes one job command at a time (optional serial kernel load, window height,
// right shift, window count). For each window it clears the BPU accumulator,
// issues one accumulate instruction per row, captures the signed popcount sum,
// and offers it on a valid/ready result port. Every output is a register.
//
// Optional feature macro: BPU_SEQ_RELU_EN
//   defined   - negative captured results are stored as 0
//   undefined - the raw signed result is passed through
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   cmd_*               job command; cmd_ready is high only while idle
//   bpu_instruction     {psum_add, lut_sel[2:0], psum_rst}
//   bpu_height          latched rows per window (0 on the command becomes 7)
//   bpu_right_shift     latched image shift
//   bpu_wgt_input/_en   serial kernel load, MSB of the kernel first
//   bpu_popcnt_add      BPU accumulator, sampled at the end of the drain cycle
//   win_next            one-cycle pulse asking the image feeder for a window
//   res_valid/ready/data window result handshake
//   done                one-cycle pulse at job end
module bpu_seq #(
    parameter int unsigned KERNEL_BITS = 49,
    parameter int unsigned WIN_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_load_wgt,
    input  logic [KERNEL_BITS-1:0] cmd_kernel,
    input  logic [2:0]             cmd_height,
    input  logic [2:0]             cmd_right_shift,
    input  logic [WIN_W-1:0]       cmd_num_win,
    output logic [4:0]             bpu_instruction,
    output logic [2:0]             bpu_height,
    output logic [2:0]             bpu_right_shift,
    output logic                   bpu_wgt_input,
    output logic                   bpu_wgt_en,
    input  logic signed [6:0]      bpu_popcnt_add,
    output logic                   win_next,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [6:0]      res_data,
    output logic                   done
);

    // Step counter covers both the kernel bit index and the ACC row index.
    localparam int unsigned StepW = (KERNEL_BITS > 8) ? $clog2(KERNEL_BITS) : 3;
    localparam logic [StepW-1:0] LoadLast = StepW'(KERNEL_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StClear,
        StAcc,
        StDrain,
        StOut,
        StFin
    } state_e;

    state_e                 state_q, state_d;
    logic [StepW-1:0]       step_q, step_d;
    logic [WIN_W-1:0]       rem_q, rem_d;
    logic [KERNEL_BITS-1:0] kern_q, kern_d;
    logic [2:0]             height_q, height_d;
    logic [2:0]             rshift_q, rshift_d;

    logic                   cmd_ready_q, cmd_ready_d;
    logic [4:0]             instr_q, instr_d;
    logic                   wgt_input_q, wgt_input_d;
    logic                   wgt_en_q, wgt_en_d;
    logic                   win_next_q, win_next_d;
    logic                   res_valid_q, res_valid_d;
    logic signed [6:0]      res_data_q, res_data_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic signed [6:0]      pop_cap;

    assign accept = cmd_valid && (state_q == StIdle);

`ifdef BPU_SEQ_RELU_EN
    assign pop_cap = bpu_popcnt_add[6] ? 7'sd0 : bpu_popcnt_add;
`else
    assign pop_cap = bpu_popcnt_add;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= '0;
            rem_q       <= '0;
            kern_q      <= '0;
            height_q    <= '0;
            rshift_q    <= '0;
            cmd_ready_q <= 1'b1;
            instr_q     <= '0;
            wgt_input_q <= 1'b0;
            wgt_en_q    <= 1'b0;
            win_next_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            rem_q       <= rem_d;
            kern_q      <= kern_d;
            height_q    <= height_d;
            rshift_q    <= rshift_d;
            cmd_ready_q <= cmd_ready_d;
            instr_q     <= instr_d;
            wgt_input_q <= wgt_input_d;
            wgt_en_q    <= wgt_en_d;
            win_next_q  <= win_next_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_load_wgt) begin
                        state_d = StLoad;
                    end else if (cmd_num_win == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = StClear;
                    end
                end
            end
            StLoad: begin
                if (step_q == LoadLast) begin
                    state_d = (rem_q == '0) ? StFin : StClear;
                end
            end
            StClear: state_d = StAcc;
            StAcc: begin
                if (step_q[2:0] == height_q - 3'd1) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StOut;
            StOut: begin
                // Last window when exactly one remains before this handshake.
                if (res_ready) begin
                    state_d = (rem_q == WIN_W'(1)) ? StFin : StClear;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: counters, kernel shifter, latched job fields.
    always_comb begin
        step_d   = step_q;
        rem_d    = rem_q;
        kern_d   = kern_q;
        height_d = height_q;
        rshift_d = rshift_q;

        if (state_d != state_q) begin
            step_d = '0;
        end else if (state_q == StLoad || state_q == StAcc) begin
            step_d = step_q + StepW'(1);
        end

        if (accept) begin
            rem_d    = cmd_num_win;
            kern_d   = cmd_kernel;
            height_d = (cmd_height == 3'd0) ? 3'd7 : cmd_height;
            rshift_d = cmd_right_shift;
        end else begin
            if (state_q == StLoad) begin
                kern_d = kern_q << 1;
            end
            if (state_q == StOut && res_ready) begin
                rem_d = rem_q - WIN_W'(1);
            end
        end
    end

    // Output logic, decoded from the next state so every output is registered
    // and lines up with the state it belongs to.
    always_comb begin
        cmd_ready_d = (state_d == StIdle);
        wgt_en_d    = (state_d == StLoad);
        wgt_input_d = (state_d == StLoad) && kern_d[KERNEL_BITS-1];
        win_next_d  = (state_d == StClear);
        res_valid_d = (state_d == StOut);
        done_d      = (state_d == StFin);

        instr_d = 5'b00000;
        if (state_d == StClear) begin
            instr_d = 5'b00001;
        end else if (state_d == StAcc) begin
            instr_d = {1'b1, step_d[2:0], 1'b0};
        end

        res_data_d = res_data_q;
        if (state_q == StDrain) begin
            res_data_d = pop_cap;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign bpu_instruction = instr_q;
    assign bpu_height      = height_q;
    assign bpu_right_shift = rshift_q;
    assign bpu_wgt_input   = wgt_input_q;
    assign bpu_wgt_en      = wgt_en_q;
    assign win_next        = win_next_q;
    assign res_valid       = res_valid_q;
    assign res_data        = res_data_q;
    assign done            = done_q;

endmodule

// File: tb/tb_bpu_seq.sv
// Bench for bpu_seq: randomized and directed jobs checked every cycle against
// an unrolled per-cycle job script, plus literal checks of the test plan items.
module tb_bpu_seq;
    localparam int KB = 49;
    localparam int WW = 8;

    localparam int KIdle  = -1;
    localparam int KLoad  = 0;
    localparam int KClear = 1;
    localparam int KAcc   = 2;
    localparam int KDrain = 3;
    localparam int KOut   = 4;
    localparam int KFin   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_load_wgt;
    logic [KB-1:0]        cmd_kernel;
    logic [2:0]           cmd_height;
    logic [2:0]           cmd_right_shift;
    logic [WW-1:0]        cmd_num_win;
    logic [4:0]           bpu_instruction;
    logic [2:0]           bpu_height;
    logic [2:0]           bpu_right_shift;
    logic                 bpu_wgt_input;
    logic                 bpu_wgt_en;
    logic signed [6:0]    bpu_popcnt_add;
    logic                 win_next;
    logic                 res_valid;
    logic                 res_ready;
    logic signed [6:0]    res_data;
    logic                 done;

    bpu_seq #(
        .KERNEL_BITS(KB),
        .WIN_W      (WW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_load_wgt   (cmd_load_wgt),
        .cmd_kernel     (cmd_kernel),
        .cmd_height     (cmd_height),
        .cmd_right_shift(cmd_right_shift),
        .cmd_num_win    (cmd_num_win),
        .bpu_instruction(bpu_instruction),
        .bpu_height     (bpu_height),
        .bpu_right_shift(bpu_right_shift),
        .bpu_wgt_input  (bpu_wgt_input),
        .bpu_wgt_en     (bpu_wgt_en),
        .bpu_popcnt_add (bpu_popcnt_add),
        .win_next       (win_next),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .done           (done)
    );

    // Model: a job is unrolled into the list of cycles it must produce.
    typedef struct {
        int         kind;
        logic [4:0] instr;
        logic       wbit;
    } step_t;

    step_t             plan[$];
    logic [2:0]        m_height = '0;
    logic [2:0]        m_rs = '0;
    logic signed [6:0] m_res = '0;

    int errors = 0;
    int checks = 0;

    // Per-job observations of the DUT.
    int            s_cyc, s_wgt_en, s_wn, s_wn_first, s_wn_last, s_rv, s_rv_first, s_done, s_acc;
    logic [KB-1:0] s_bits;
    logic [4:0]    s_instr[$];
    logic signed [6:0] s_res_last;
    logic          prev_rv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [6:0] cap(input logic signed [6:0] v);
`ifdef BPU_SEQ_RELU_EN
        return (v < 0) ? 7'sd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic void build_plan(input bit load, input logic [KB-1:0] kern,
                                       input logic [2:0] h, input logic [WW-1:0] nw);
        step_t e;
        int    heff;
        plan.delete();
        heff = (h == 0) ? 7 : int'(h);
        if (load) begin
            for (int k = 0; k < KB; k++) begin
                e.kind = KLoad; e.instr = 5'h00; e.wbit = kern[KB-1-k];
                plan.push_back(e);
            end
        end
        for (int w = 0; w < int'(nw); w++) begin
            e.kind = KClear; e.instr = 5'h01; e.wbit = 1'b0;
            plan.push_back(e);
            for (int r = 0; r < heff; r++) begin
                e.kind = KAcc; e.instr = {1'b1, 3'(r), 1'b0};
                plan.push_back(e);
            end
            e.kind = KDrain; e.instr = 5'h00;
            plan.push_back(e);
            e.kind = KOut;
            plan.push_back(e);
        end
        e.kind = KFin; e.instr = 5'h00; e.wbit = 1'b0;
        plan.push_back(e);
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        if (rst) begin
            plan.delete();
            m_height = '0;
            m_rs     = '0;
            m_res    = '0;
        end else if (plan.size() == 0) begin
            if (cmd_valid) begin
                m_height = (cmd_height == 0) ? 3'd7 : cmd_height;
                m_rs     = cmd_right_shift;
                build_plan(cmd_load_wgt, cmd_kernel, cmd_height, cmd_num_win);
            end
        end else if (!(plan[0].kind == KOut && !res_ready)) begin
            if (plan[0].kind == KDrain) m_res = cap(bpu_popcnt_add);
            void'(plan.pop_front());
        end
    endtask

    task automatic compare_all();
        int         k;
        logic [4:0] e_instr;
        logic       e_wbit;
        k       = (plan.size() != 0) ? plan[0].kind : KIdle;
        e_instr = (k != KIdle) ? plan[0].instr : 5'h00;
        e_wbit  = (k == KLoad) ? plan[0].wbit : 1'b0;
        check("cmd_ready", 64'(cmd_ready), 64'(k == KIdle));
        check("bpu_instruction", 64'(bpu_instruction), 64'(e_instr));
        check("bpu_height", 64'(bpu_height), 64'(m_height));
        check("bpu_right_shift", 64'(bpu_right_shift), 64'(m_rs));
        check("bpu_wgt_en", 64'(bpu_wgt_en), 64'(k == KLoad));
        check("bpu_wgt_input", 64'(bpu_wgt_input), 64'(e_wbit));
        check("win_next", 64'(win_next), 64'(k == KClear));
        check("res_valid", 64'(res_valid), 64'(k == KOut));
        check("res_data", 64'(res_data), 64'(m_res));
        check("done", 64'(done), 64'(k == KFin));

        s_cyc++;
        if (bpu_wgt_en === 1'b1) begin
            s_wgt_en++;
            s_bits = {s_bits[KB-2:0], bpu_wgt_input};
        end
        if (win_next === 1'b1) begin
            s_wn++;
            if (s_wn_first < 0) s_wn_first = s_cyc;
            s_wn_last = s_cyc;
        end
        if (s_wn > 0) s_instr.push_back(bpu_instruction);
        if (bpu_instruction[4] === 1'b1) s_acc++;
        if (res_valid === 1'b1 && prev_rv !== 1'b1) begin
            s_rv++;
            if (s_rv_first < 0) s_rv_first = s_cyc;
        end
        if (res_valid === 1'b1) s_res_last = res_data;
        prev_rv = res_valid;
        if (done === 1'b1) s_done++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_stats();
        s_cyc = 0; s_wgt_en = 0; s_wn = 0; s_wn_first = -1; s_wn_last = -1;
        s_rv = 0; s_rv_first = -1; s_done = 0; s_acc = 0; s_bits = '0;
        s_instr.delete(); s_res_last = '0; prev_rv = 1'b0;
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = hold low for 'stall' cycles in the first OUT.
    task automatic run_job(input bit load, input logic [KB-1:0] kern, input logic [2:0] h,
                           input logic [2:0] rs, input logic [WW-1:0] nw, input int ready_mode,
                           input int stall, input bit fixed_pop, input logic signed [6:0] pop_val,
                           input bit rst_in_acc);
        int guard;
        int stall_left;
        bit did_rst;
        clear_stats();
        stall_left      = stall;
        did_rst         = 1'b0;
        cmd_valid       = 1'b1;
        cmd_load_wgt    = load;
        cmd_kernel      = kern;
        cmd_height      = h;
        cmd_right_shift = rs;
        cmd_num_win     = nw;
        res_ready       = 1'b1;
        bpu_popcnt_add  = fixed_pop ? pop_val : 7'($urandom);
        tick();
        cmd_valid = 1'b0;
        guard = 0;
        while (plan.size() != 0 && guard < 20000) begin
            case (ready_mode)
                0: res_ready = 1'b1;
                1: res_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (plan[0].kind == KOut && stall_left > 0) begin
                        res_ready = 1'b0;
                        stall_left--;
                    end else begin
                        res_ready = 1'b1;
                    end
                end
            endcase
            bpu_popcnt_add = fixed_pop ? pop_val : 7'($urandom);
            if (ready_mode == 1) begin
                // Commands while busy must be ignored.
                cmd_valid       = ($urandom_range(0, 5) == 0);
                cmd_load_wgt    = 1'($urandom);
                cmd_kernel      = {17'($urandom), 32'($urandom)};
                cmd_height      = 3'($urandom);
                cmd_right_shift = 3'($urandom);
                cmd_num_win     = 8'($urandom);
            end
            if (rst_in_acc && !did_rst && plan[0].kind == KAcc) begin
                rst     = 1'b1;
                did_rst = 1'b1;
            end
            tick();
            rst = 1'b0;
            guard++;
        end
        cmd_valid = 1'b0;
        if (guard >= 20000) check("job_timeout", 64'(guard), 64'(0));
    endtask

    initial begin
        logic signed [6:0] exp_neg;
        logic [4:0]        exp_b[12];
        rst = 1'b1; cmd_valid = 1'b0; cmd_load_wgt = 1'b0; cmd_kernel = '0;
        cmd_height = '0; cmd_right_shift = '0; cmd_num_win = '0;
        res_ready = 1'b0; bpu_popcnt_add = '0;
        clear_stats();
        tick();
        tick();
        check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        check("reset_instr", 64'(bpu_instruction), 64'(0));
        check("reset_res_valid", 64'(res_valid), 64'(0));
        rst = 1'b0;
        tick();

        // Kernel load, alternating bits.
        run_job(1'b1, 49'h1_5555_5555_5555, 3'd7, 3'd2, 8'd1, 0, 0, 1'b0, 7'sd0, 1'b0);
        check("load_wgt_en_cycles", 64'(s_wgt_en), 64'(49));
        check("load_bits", 64'(s_bits), 64'(49'h1_5555_5555_5555));
        check("load_acc_cycles", 64'(s_acc), 64'(7));
        check("load_done", 64'(s_done), 64'(1));

        // No load, height 3, two windows.
        run_job(1'b0, '0, 3'd3, 3'd5, 8'd2, 0, 0, 1'b0, 7'sd0, 1'b0);
        exp_b = '{5'h01, 5'h10, 5'h12, 5'h14, 5'h00, 5'h00,
                  5'h01, 5'h10, 5'h12, 5'h14, 5'h00, 5'h00};
        for (int i = 0; i < 12; i++) begin
            check($sformatf("h3_instr_%0d", i),
                  64'((i < s_instr.size()) ? s_instr[i] : 5'h1f), 64'(exp_b[i]));
        end
        check("h3_win_next", 64'(s_wn), 64'(2));
        check("h3_done", 64'(s_done), 64'(1));
        check("h3_valid_latency", 64'(s_rv_first - s_wn_first), 64'(5));

        // Height 0 means 7.
        run_job(1'b0, '0, 3'd0, 3'd1, 8'd1, 0, 0, 1'b0, 7'sd0, 1'b0);
        check("h0_bpu_height", 64'(bpu_height), 64'(7));
        check("h0_acc_cycles", 64'(s_acc), 64'(7));
        check("h0_last_lut", 64'((s_instr.size() > 7) ? s_instr[7] : 5'h00), 64'(5'h1c));

        // Ten-cycle stall in OUT, then release.
        run_job(1'b0, '0, 3'd2, 3'd0, 8'd2, 2, 10, 1'b0, 7'sd0, 1'b0);
        check("stall_win_next", 64'(s_wn), 64'(2));
        check("stall_next_clear", 64'(s_wn_last), 64'(16));

        // Negative accumulator.
`ifdef BPU_SEQ_RELU_EN
        exp_neg = 7'sd0;
`else
        exp_neg = -7'sd5;
`endif
        run_job(1'b0, '0, 3'd1, 3'd0, 8'd1, 0, 0, 1'b1, -7'sd5, 1'b0);
        check("neg_res_data", 64'(s_res_last), 64'(exp_neg));

        // Zero windows with load.
        run_job(1'b1, 49'h0_f0f0_1234_abcd, 3'd4, 3'd3, 8'd0, 0, 0, 1'b0, 7'sd0, 1'b0);
        check("nw0_wgt_en_cycles", 64'(s_wgt_en), 64'(49));
        check("nw0_done", 64'(s_done), 64'(1));
        check("nw0_res_valid", 64'(s_rv), 64'(0));

        // Reset during ACC, then a fresh job.
        run_job(1'b0, '0, 3'd5, 3'd6, 8'd3, 0, 0, 1'b0, 7'sd0, 1'b1);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_bpu_height", 64'(bpu_height), 64'(0));
        run_job(1'b1, 49'h1_2345_6789_abcd, 3'd4, 3'd2, 8'd2, 0, 0, 1'b0, 7'sd0, 1'b0);
        check("after_rst_results", 64'(s_rv), 64'(2));
        check("after_rst_done", 64'(s_done), 64'(1));

        // Full-range window count.
        run_job(1'b0, '0, 3'd1, 3'd0, 8'd255, 0, 0, 1'b0, 7'sd0, 1'b0);
        check("wrap_results", 64'(s_rv), 64'(255));
        check("wrap_done", 64'(s_done), 64'(1));

        // Random jobs.
        for (int j = 0; j < 30; j++) begin
            run_job(($urandom_range(0, 3) == 0), {17'($urandom), 32'($urandom)},
                    3'($urandom), 3'($urandom), 8'($urandom_range(0, 6)), 1, 0, 1'b0, 7'sd0,
                    ($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) begin
                bpu_popcnt_add = 7'($urandom);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
